// File: rtl/mips_jump_pkg.sv
// Shared decode constants and the jump-kind encoding for the ID-stage jump unit.
package mips_jump_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] RA_REG     = 5'd31;

    typedef enum logic [2:0] {
        JK_NONE = 3'd0,
        JK_J    = 3'd1,
        JK_JAL  = 3'd2,
        JK_JR   = 3'd3,
        JK_JALR = 3'd4
    } jump_kind_e;

    function automatic jump_kind_e decodeKind(input logic [5:0] op, input logic [5:0] funct);
        jump_kind_e kind;
        kind = JK_NONE;
        if (op == OP_J) begin
            kind = JK_J;
        end else if (op == OP_JAL) begin
            kind = JK_JAL;
        end else if (op == OP_SPECIAL && funct == FN_JR) begin
            kind = JK_JR;
        end else if (op == OP_SPECIAL && funct == FN_JALR) begin
            kind = JK_JALR;
        end
        return kind;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a wrapping write pointer plus a saturating occupancy counter.
module ras_stack
    import mips_jump_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wrIdx;
    logic             doPop;

    assign doPop   = i_pop && (count_q != '0);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_top   = mem_q[ptr_q - 1'b1];

    // A simultaneous pop and push rewrites the top slot in place.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wrIdx   = doPop ? (ptr_q - 1'b1) : ptr_q;
        if (i_push && !doPop) begin
            ptr_d = ptr_q + 1'b1;
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end else if (doPop && !i_push) begin
            ptr_d   = ptr_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem_q[wrIdx] <= i_din;
        end
    end

endmodule

// File: rtl/u_jump_ras.sv
// MIPS ID-stage jump unit: decodes J/JAL/JR/JALR, registers target/link for one cycle, checks JR $31 against a RAS.
module u_jump_ras
    import mips_jump_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SIZEOP     = 6,
    parameter int RAS_DEPTH  = 8,
    parameter int RA_OFFSET  = 4,
    parameter bit ABS_TARGET = 1'b1,
    localparam int CW = $clog2(RAS_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_currentpc,
    input  logic [DATA_WIDTH-1:0] i_instruccion,
    input  logic [DATA_WIDTH-1:0] i_regA,
    output logic                  o_jump,
    output logic [DATA_WIDTH-1:0] o_pcjump,
    output logic [DATA_WIDTH-1:0] o_return_address,
    output logic                  o_rd_selector,
    output logic                  o_return,
    output logic                  o_ras_mispredict,
    output logic [CW-1:0]         o_ras_count
);

    logic [SIZEOP-1:0]     op, funct;
    logic [4:0]            rs;
    jump_kind_e            kind;
    logic                  accept, rsIsRa, rasEmpty, rasMiss, push, pop;
    logic [DATA_WIDTH-1:0] link, target, rasTop;

    logic                  jump_q, jump_d, ret_q, ret_d, rdSel_q, rdSel_d, misp_q, misp_d;
    logic [DATA_WIDTH-1:0] pcJump_q, pcJump_d, retAddr_q, retAddr_d;

    assign op      = i_instruccion[DATA_WIDTH-1 -: SIZEOP];
    assign funct   = i_instruccion[SIZEOP-1:0];
    assign rs      = i_instruccion[25:21];
    assign kind    = decodeKind(op, funct);
    assign rsIsRa  = (rs == RA_REG);
    assign accept  = i_valid && !i_stall && !i_flush;
    assign link    = i_currentpc + DATA_WIDTH'(RA_OFFSET);
    assign target  = ABS_TARGET ? {i_currentpc[DATA_WIDTH-1:28], i_instruccion[25:0], 2'b00}
                                : i_currentpc + DATA_WIDTH'({i_instruccion[25:0], 2'b00});
    assign rasMiss = rasEmpty || (rasTop != i_regA);
    assign push    = accept && (kind == JK_JAL || kind == JK_JALR);
    assign pop     = accept && rsIsRa && (kind == JK_JR || kind == JK_JALR);

    ras_stack #(.DEPTH(RAS_DEPTH), .WIDTH(DATA_WIDTH)) u_ras (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_pop   (pop),
        .i_din   (link),
        .o_top   (rasTop),
        .o_empty (rasEmpty),
        .o_count (o_ras_count)
    );

    // Flush only drops the control flags; target and link values simply hold.
    always_comb begin
        jump_d    = jump_q;
        ret_d     = ret_q;
        rdSel_d   = rdSel_q;
        misp_d    = misp_q;
        pcJump_d  = pcJump_q;
        retAddr_d = retAddr_q;
        if (!i_stall) begin
            jump_d = 1'b0;
            ret_d  = 1'b0;
            misp_d = 1'b0;
            if (!i_flush) begin
                rdSel_d = 1'b0;
                if (i_valid) begin
                    case (kind)
                        JK_J: begin
                            jump_d   = 1'b1;
                            pcJump_d = target;
                        end
                        JK_JAL: begin
                            jump_d    = 1'b1;
                            ret_d     = 1'b1;
                            rdSel_d   = 1'b1;
                            pcJump_d  = target;
                            retAddr_d = link;
                        end
                        JK_JR: begin
                            jump_d   = 1'b1;
                            pcJump_d = i_regA;
                            misp_d   = rsIsRa && rasMiss;
                        end
                        JK_JALR: begin
                            jump_d    = 1'b1;
                            ret_d     = 1'b1;
                            pcJump_d  = i_regA;
                            retAddr_d = link;
                            misp_d    = rsIsRa && rasMiss;
                        end
                        default: begin
                            jump_d = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            jump_q    <= 1'b0;
            ret_q     <= 1'b0;
            rdSel_q   <= 1'b0;
            misp_q    <= 1'b0;
            pcJump_q  <= '0;
            retAddr_q <= '0;
        end else begin
            jump_q    <= jump_d;
            ret_q     <= ret_d;
            rdSel_q   <= rdSel_d;
            misp_q    <= misp_d;
            pcJump_q  <= pcJump_d;
            retAddr_q <= retAddr_d;
        end
    end

    assign o_jump           = jump_q;
    assign o_return         = ret_q;
    assign o_rd_selector    = rdSel_q;
    assign o_ras_mispredict = misp_q;
    assign o_pcjump         = pcJump_q;
    assign o_return_address = retAddr_q;

endmodule

// File: tb/tb_u_jump_ras.sv
// Bench for u_jump_ras: directed vector table, hand-written corner sequences, and randomized traffic vs a queue-based model.
module tb_u_jump_ras;

    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, i_stall, i_flush;
    logic [31:0] i_currentpc, i_instruccion, i_regA;
    logic        o_jump, o_rd_selector, o_return, o_ras_mispredict;
    logic [31:0] o_pcjump, o_return_address;
    logic [3:0]  o_ras_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: registered outputs plus the RAS as a queue (newest at the back).
    logic        mJump, mRet, mRdSel, mMisp;
    logic [31:0] mPcJump, mRetAddr;
    logic [31:0] ras[$];

    u_jump_ras dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_valid          (i_valid),
        .i_stall          (i_stall),
        .i_flush          (i_flush),
        .i_currentpc      (i_currentpc),
        .i_instruccion    (i_instruccion),
        .i_regA           (i_regA),
        .o_jump           (o_jump),
        .o_pcjump         (o_pcjump),
        .o_return_address (o_return_address),
        .o_rd_selector    (o_rd_selector),
        .o_return         (o_return),
        .o_ras_mispredict (o_ras_mispredict),
        .o_ras_count      (o_ras_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mkJ(input logic [25:0] imm);
        return {6'b000010, imm};
    endfunction
    function automatic logic [31:0] mkJal(input logic [25:0] imm);
        return {6'b000011, imm};
    endfunction
    function automatic logic [31:0] mkJr(input logic [4:0] rs);
        return {6'b000000, rs, 15'd0, 6'b001000};
    endfunction
    function automatic logic [31:0] mkJalr(input logic [4:0] rs, input logic [4:0] rd);
        return {6'b000000, rs, 5'd0, rd, 5'd0, 6'b001001};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic modelStep(input logic rst, input logic valid, input logic stall, input logic flush,
                             input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] regA);
        logic isJ, isJal, isJr, isJalr;
        if (rst) begin
            {mJump, mRet, mRdSel, mMisp} = 4'b0;
            mPcJump = 32'h0;
            mRetAddr = 32'h0;
            ras.delete();
        end else if (stall) begin
            // everything held
        end else if (flush) begin
            mJump = 1'b0;
            mRet = 1'b0;
            mMisp = 1'b0;
        end else begin
            isJ    = valid && instr[31:26] == 6'd2;
            isJal  = valid && instr[31:26] == 6'd3;
            isJr   = valid && instr[31:26] == 6'd0 && instr[5:0] == 6'd8;
            isJalr = valid && instr[31:26] == 6'd0 && instr[5:0] == 6'd9;
            mJump  = isJ || isJal || isJr || isJalr;
            mRet   = isJal || isJalr;
            mRdSel = isJal;
            mMisp  = 1'b0;
            if (isJ || isJal) mPcJump = {pc[31:28], instr[25:0], 2'b00};
            if (isJr || isJalr) mPcJump = regA;
            if (isJal || isJalr) mRetAddr = pc + 32'd4;
            if ((isJr || isJalr) && instr[25:21] == 5'd31) begin
                mMisp = (ras.size() == 0) || (ras[$] != regA);
                if (ras.size() > 0) void'(ras.pop_back());
            end
            if (isJal || isJalr) begin
                ras.push_back(pc + 32'd4);
                if (ras.size() > 8) void'(ras.pop_front());
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and sample 1 time unit after the edge.
    task automatic applyStimulus(input logic rst, input logic valid, input logic stall, input logic flush,
                                 input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] regA);
        i_reset = rst;
        i_valid = valid;
        i_stall = stall;
        i_flush = flush;
        i_currentpc = pc;
        i_instruccion = instr;
        i_regA = regA;
        modelStep(rst, valid, stall, flush, pc, instr, regA);
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        if (o_jump !== mJump || o_return !== mRet || o_rd_selector !== mRdSel || o_ras_mispredict !== mMisp ||
            o_pcjump !== mPcJump || o_return_address !== mRetAddr || o_ras_count !== 4'(ras.size())) begin
            failures++;
            $display("[TB] FAIL %s actual j=%0b r=%0b sel=%0b mp=%0b pc=0x%0h ra=0x%0h cnt=%0d required j=%0b r=%0b sel=%0b mp=%0b pc=0x%0h ra=0x%0h cnt=%0d",
                     tag, o_jump, o_return, o_rd_selector, o_ras_mispredict, o_pcjump, o_return_address, o_ras_count,
                     mJump, mRet, mRdSel, mMisp, mPcJump, mRetAddr, ras.size());
        end
    endtask

    task automatic checkZero(input string tag);
        checkVal({tag, "_jump"}, 32'(o_jump), 32'h0);
        checkVal({tag, "_pcjump"}, o_pcjump, 32'h0);
        checkVal({tag, "_retaddr"}, o_return_address, 32'h0);
        checkVal({tag, "_rdsel"}, 32'(o_rd_selector), 32'h0);
        checkVal({tag, "_return"}, 32'(o_return), 32'h0);
        checkVal({tag, "_misp"}, 32'(o_ras_mispredict), 32'h0);
        checkVal({tag, "_count"}, 32'(o_ras_count), 32'h0);
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] pc, instr, regA;
        logic        expJump;
        logic [31:0] expPc, expRa;
        logic        expRdSel, expRet, expMisp;
        logic [3:0]  expCnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] instr, regA, pc;
        int kind;

        vecs[0] = '{1'b1, 32'h0040_0000, mkJ(26'h10),        32'h0,   1'b1, 32'h40,  32'h0,   1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{1'b1, 32'h0000_0100, mkJal(26'h0),       32'h0,   1'b1, 32'h0,   32'h104, 1'b1, 1'b1, 1'b0, 4'd1};
        vecs[2] = '{1'b1, 32'h0000_0000, mkJr(5'd31),        32'h104, 1'b1, 32'h104, 32'h104, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[3] = '{1'b1, 32'h0000_0000, mkJr(5'd31),        32'h200, 1'b1, 32'h200, 32'h104, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[4] = '{1'b1, 32'h0000_0010, 32'h0000_0000,      32'h0,   1'b0, 32'h200, 32'h104, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[5] = '{1'b1, 32'h0000_0020, mkJr(5'd5),         32'h300, 1'b1, 32'h300, 32'h104, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[6] = '{1'b1, 32'h0000_004C, mkJal(26'h40),      32'h0,   1'b1, 32'h100, 32'h50,  1'b1, 1'b1, 1'b0, 4'd1};
        vecs[7] = '{1'b1, 32'h0000_0200, mkJalr(5'd31, 5'd2), 32'h50, 1'b1, 32'h50,  32'h204, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[8] = '{1'b1, 32'h0000_0300, mkJr(5'd31),        32'h204, 1'b1, 32'h204, 32'h204, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[9] = '{1'b0, 32'h0000_0400, mkJ(26'h5),         32'h0,   1'b0, 32'h204, 32'h204, 1'b0, 1'b0, 1'b0, 4'd0};

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checkZero("reset");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, vecs[i].valid, 1'b0, 1'b0, vecs[i].pc, vecs[i].instr, vecs[i].regA);
            checkVal($sformatf("vec%0d_jump", i), 32'(o_jump), 32'(vecs[i].expJump));
            checkVal($sformatf("vec%0d_pcjump", i), o_pcjump, vecs[i].expPc);
            checkVal($sformatf("vec%0d_retaddr", i), o_return_address, vecs[i].expRa);
            checkVal($sformatf("vec%0d_rdsel", i), 32'(o_rd_selector), 32'(vecs[i].expRdSel));
            checkVal($sformatf("vec%0d_return", i), 32'(o_return), 32'(vecs[i].expRet));
            checkVal($sformatf("vec%0d_misp", i), 32'(o_ras_mispredict), 32'(vecs[i].expMisp));
            checkVal($sformatf("vec%0d_count", i), 32'(o_ras_count), 32'(vecs[i].expCnt));
        end

        // Overflow: nine calls into an eight-entry stack lose the oldest link.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'(i * 4), mkJal(26'h0), 32'h0);
            checkVal($sformatf("fill%0d_count", i), 32'(o_ras_count), (i + 1 > 8) ? 32'd8 : 32'(i + 1));
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000, mkJr(5'd31), 32'h24 - 32'(4 * k));
            checkVal($sformatf("drain%0d_misp", k), 32'(o_ras_mispredict), 32'h0);
            checkVal($sformatf("drain%0d_count", k), 32'(o_ras_count), 32'(7 - k));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000, mkJr(5'd31), 32'h4);
        checkVal("drain_empty_misp", 32'(o_ras_mispredict), 32'h1);
        checkVal("drain_empty_count", 32'(o_ras_count), 32'h0);

        // Stall holds everything; release pushes once; flush cancels.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, mkJal(26'h0), 32'h0);
            checkVal($sformatf("stall%0d_jump", s), 32'(o_jump), 32'h0);
            checkVal($sformatf("stall%0d_count", s), 32'(o_ras_count), 32'h0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, mkJal(26'h0), 32'h0);
        checkVal("release_jump", 32'(o_jump), 32'h1);
        checkVal("release_retaddr", o_return_address, 32'h104);
        checkVal("release_count", 32'(o_ras_count), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h0, 32'h0);
        checkVal("after_release_count", 32'(o_ras_count), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, mkJal(26'h0), 32'h0);
        checkVal("flush_jump", 32'(o_jump), 32'h0);
        checkVal("flush_return", 32'(o_return), 32'h0);
        checkVal("flush_count", 32'(o_ras_count), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0000, mkJ(26'h10), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
        checkVal("stall_over_flush_jump", 32'(o_jump), 32'h1);
        checkVal("stall_over_flush_pc", o_pcjump, 32'h40);

        // JALR $31 replaces the top, then reset lands on a stalled call.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h4C, mkJal(26'h0), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, mkJalr(5'd31, 5'd4), 32'h50);
        checkVal("jalr31_misp", 32'(o_ras_mispredict), 32'h0);
        checkVal("jalr31_count", 32'(o_ras_count), 32'h2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, mkJr(5'd31), 32'h204);
        checkVal("jalr31_newtop_misp", 32'(o_ras_mispredict), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h600, mkJal(26'h8), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h700, mkJal(26'h8), 32'h0);
        checkZero("mid_reset");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 7);
            pc = $urandom() & 32'hFFFF_FFFC;
            case (kind)
                0: instr = mkJ(26'($urandom()));
                1, 2: instr = mkJal(26'($urandom()));
                3: instr = mkJr(5'd31);
                4: instr = mkJr(5'($urandom_range(0, 30)));
                5: instr = mkJalr(5'd31, 5'($urandom()));
                6: instr = mkJalr(5'($urandom_range(0, 30)), 5'($urandom()));
                default: instr = $urandom();
            endcase
            regA = (ras.size() > 0 && $urandom_range(0, 2) != 0) ? ras[$] : $urandom();
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                          $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0, pc, instr, regA);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
